// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - chunked carry-chained pipelined add/sub with valid/ready and sum/carry/ovf/zero flags
// Optional signed saturation when ADDSUB_SAT_EN is defined.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int L     = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_addsub: STAGES must be 1..WIDTH and divide WIDTH");
    end

    logic             adv;
    logic [STAGES-1:0] pv, pc, sv, scin, nc;
    logic [WIDTH-1:0] pa [STAGES];
    logic [WIDTH-1:0] pb [STAGES];
    logic [WIDTH-1:0] ps [STAGES];
    logic [WIDTH-1:0] sa [STAGES];
    logic [WIDTH-1:0] sb [STAGES];
    logic [WIDTH-1:0] ss [STAGES];
    logic [WIDTH-1:0] ns [STAGES];
    logic [CHUNK:0]   part [STAGES];
    logic             raw_ovf, fin_zero, povf, pzero;
    logic [WIDTH-1:0] fin_sum;
`ifdef ADDSUB_SAT_EN
    logic             psat [STAGES];
    logic             ssat [STAGES];
`endif

    assign adv       = !pv[L] || out_ready;
    assign in_ready  = adv;
    assign out_valid = pv[L];
    assign out_sum   = ps[L];
    assign out_cout  = pc[L];
    assign out_ovf   = povf;
    assign out_zero  = pzero;

    // Operand source of each stage: the input ports for stage 0, otherwise the previous stage register.
    always_comb begin
        sv[0]   = in_valid;
        sa[0]   = in_a;
        sb[0]   = in_sub ? ~in_b : in_b;
        scin[0] = in_sub;
        ss[0]   = '0;
`ifdef ADDSUB_SAT_EN
        ssat[0] = in_sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            sv[k]   = pv[k-1];
            sa[k]   = pa[k-1];
            sb[k]   = pb[k-1];
            scin[k] = pc[k-1];
            ss[k]   = ps[k-1];
`ifdef ADDSUB_SAT_EN
            ssat[k] = psat[k-1];
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, sa[k][k*CHUNK +: CHUNK]} + {1'b0, sb[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, scin[k]};
            ns[k] = ss[k];
            ns[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
            nc[k] = part[k][CHUNK];
        end
    end

    // Overflow is judged on the wrapped sum; zero on whatever is finally presented.
    always_comb begin
        raw_ovf = (sa[L][WIDTH-1] == sb[L][WIDTH-1]) && (ns[L][WIDTH-1] != sa[L][WIDTH-1]);
        fin_sum = ns[L];
`ifdef ADDSUB_SAT_EN
        if (ssat[L] && raw_ovf) begin
            fin_sum = sa[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        fin_zero = (fin_sum == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv    <= '0;
            pc    <= '0;
            povf  <= 1'b0;
            pzero <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                ps[k] <= '0;
            end
        end else if (adv) begin
            pv <= sv;
            // Bubbles leave stage data untouched so a drained output keeps its last value.
            for (int k = 0; k < STAGES; k++) begin
                if (sv[k]) begin
                    pa[k] <= sa[k];
                    pb[k] <= sb[k];
                    pc[k] <= nc[k];
                    ps[k] <= (k == L) ? fin_sum : ns[k];
`ifdef ADDSUB_SAT_EN
                    psat[k] <= ssat[k];
`endif
                end
            end
            if (sv[L]) begin
                povf  <= raw_ovf;
                pzero <= fin_zero;
            end
        end
    end

endmodule
